// File: rtl/soc_bus_arbiter.sv
// soc_bus_arbiter: two-master round-robin arbiter in front of the shared RAM/IO slave.
// Latency: request in cycle T -> slave strobe at T+1; a zero-wait read has rdata/rbusy=0 at T+3.
// Backpressure: each master is held on mN_rbusy/mN_wbusy; a request while busy is dropped and flagged.
// Ports: clk, reset (async, active low); m0_*/m1_* master request and response;
//   s_* shared slave bus; grant_id = owning master while not IDLE;
//   proto_err = sticky flag, set by a request from a master that is still busy.
module soc_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_wmask,
  input  logic                    m0_rstrb,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  output logic                    m0_rbusy,
  output logic                    m0_wbusy,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_wmask,
  input  logic                    m1_rstrb,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    m1_rbusy,
  output logic                    m1_wbusy,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  output logic [DATA_WIDTH/8-1:0] s_wmask,
  output logic                    s_rstrb,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  input  logic                    s_rbusy,
  input  logic                    s_wbusy,
  output logic                    grant_id,
  output logic                    proto_err
);

  localparam int MW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, WWAIT} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MW-1:0]         wmask;
    logic                  is_wr;
  } slot_t;

  state_t                state_q, state_d;
  slot_t                 req_slot [2];
  slot_t                 slot_q   [2];
  slot_t                 slot_d   [2];
  logic [1:0]            req, pend_q, pend_d, done_vec, in_use, accept;
  logic                  done, last_q, grant_d, iss_rd_q;
  logic [MW-1:0]         iss_mask_q;
  logic [1:0]            rbusy_q, wbusy_q;
  logic [DATA_WIDTH-1:0] rdata_q [2];

  // Incoming requests; a nonzero mask makes it a write, so a simultaneous rstrb is ignored.
  always_comb begin
    req_slot[0].addr  = m0_addr;
    req_slot[0].wdata = m0_wdata;
    req_slot[0].wmask = m0_wmask;
    req_slot[0].is_wr = |m0_wmask;
    req_slot[1].addr  = m1_addr;
    req_slot[1].wdata = m1_wdata;
    req_slot[1].wmask = m1_wmask;
    req_slot[1].is_wr = |m1_wmask;
    req[0] = m0_rstrb | (|m0_wmask);
    req[1] = m1_rstrb | (|m1_wmask);
  end

  // Slot bookkeeping. A slot completing this cycle counts as free, so its master
  // can issue its next request in the completion cycle without tripping proto_err.
  always_comb begin
    done = ((state_q == RWAIT) && !s_rbusy) || ((state_q == WWAIT) && !s_wbusy);
    done_vec = 2'b00;
    if (done) done_vec[grant_id] = 1'b1;
    in_use = pend_q & ~done_vec;
    accept = req & ~in_use;
    pend_d = accept | in_use;
    for (int n = 0; n < 2; n++) begin
      slot_d[n] = accept[n] ? req_slot[n] : slot_q[n];
    end
    // Round robin: with both pending, take the master not granted last.
    grant_d = pend_d[1] & (~pend_d[0] | ~last_q);
  end

  // IDLE looks at slots as they will be after this edge, so a request in
  // cycle T is already on the slave bus in T+1.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|pend_d) state_d = ISSUE;
      ISSUE:   state_d = iss_rd_q ? RWAIT : WWAIT;
      RWAIT:   if (!s_rbusy) state_d = IDLE;
      WWAIT:   if (!s_wbusy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode from state so an asynchronous reset kills them immediately.
  assign s_rstrb  = (state_q == ISSUE) && iss_rd_q;
  assign s_wmask  = ((state_q == ISSUE) && !iss_rd_q) ? iss_mask_q : '0;
  assign m0_rbusy = rbusy_q[0];
  assign m0_wbusy = wbusy_q[0];
  assign m1_rbusy = rbusy_q[1];
  assign m1_wbusy = wbusy_q[1];
  assign m0_rdata = rdata_q[0];
  assign m1_rdata = rdata_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      slot_q[0]  <= '0;
      slot_q[1]  <= '0;
      last_q     <= 1'b1;   // pretend m1 went last so m0 wins the first tie
      grant_id   <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
      iss_mask_q <= '0;
      iss_rd_q   <= 1'b0;
      rbusy_q    <= '0;
      wbusy_q    <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
      proto_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      slot_q[0] <= slot_d[0];
      slot_q[1] <= slot_d[1];
      proto_err <= proto_err | (|(req & in_use));

      // Bus fields are latched once at issue and held until back in IDLE.
      if ((state_q == IDLE) && (|pend_d)) begin
        grant_id   <= grant_d;
        s_addr     <= slot_d[grant_d].addr;
        s_wdata    <= slot_d[grant_d].wdata;
        iss_mask_q <= slot_d[grant_d].wmask;
        iss_rd_q   <= ~slot_d[grant_d].is_wr;
      end

      if (done) last_q <= grant_id;
      if ((state_q == RWAIT) && !s_rbusy) rdata_q[grant_id] <= s_rdata;

      // Completion clears first; a same-cycle new request then re-raises busy.
      for (int n = 0; n < 2; n++) begin
        if (done_vec[n]) begin
          rbusy_q[n] <= 1'b0;
          wbusy_q[n] <= 1'b0;
        end
        if (accept[n]) begin
          rbusy_q[n] <= ~req_slot[n].is_wr;
          wbusy_q[n] <= req_slot[n].is_wr;
        end
      end
    end
  end

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// tb_soc_bus_arbiter: scoreboard bench for soc_bus_arbiter with a wait-state slave model.
// Latency: expected slave transactions queued at request time, compared when the strobe appears.
// Backpressure: slave wait states set per test through wait_n.
module tb_soc_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m0_wmask = '0, m1_wmask = '0;
  logic        m0_rstrb = 1'b0, m1_rstrb = 1'b0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wmask;
  logic        s_rstrb;
  logic [31:0] s_rdata = '0;
  logic        s_rbusy = 1'b0, s_wbusy = 1'b0;
  logic        grant_id, proto_err;

  typedef struct {
    logic        id;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        wr;
  } sb_t;

  sb_t         exp_q[$];
  logic        glog[$];
  int          n_checks = 0, n_errs = 0, n_strobe = 0;
  int          cnt = 0, wait_n = 0, made = 0, issued = 0, base = 0;
  logic        rd_pend = 1'b0, r0 = 1'b0, r1 = 1'b0;
  logic [31:0] rd_val = '0;

  soc_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rstrb(s_rstrb),
    .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy),
    .grant_id(grant_id), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic id, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input logic wr);
    sb_t e;
    e.id = id; e.addr = a; e.wdata = d; e.mask = m; e.wr = wr;
    exp_q.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_rstrb = 1'b0; m0_wmask = '0;
    m1_rstrb = 1'b0; m1_wmask = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Slave model: busy for wait_n cycles after a strobe; garbage data while busy.
  // Every strobe is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      cnt = 0;
      rd_pend = 1'b0;
    end else if (s_rstrb || (s_wmask != 4'h0)) begin
      n_strobe++;
      if (exp_q.size() == 0) begin
        check_val("sb_extra_strobe", {s_rstrb, s_wmask}, 5'h0);
      end else begin
        sb_t e;
        e = exp_q.pop_front();
        check_val("sb_grant", grant_id, e.id);
        check_val("sb_addr", s_addr, e.addr);
        check_val("sb_kind", {s_rstrb, s_wmask}, e.wr ? {1'b0, e.mask} : 5'h10);
        if (e.wr) check_val("sb_wdata", s_wdata, e.wdata);
      end
      cnt = wait_n + 1;
      rd_pend = s_rstrb;
    end else if (cnt > 0) begin
      cnt--;
    end
    s_rbusy = rd_pend && (cnt > 0);
    s_wbusy = !rd_pend && (cnt > 0);
    s_rdata = (cnt > 0) ? (32'hBAD0_0000 | cnt) : rd_val;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    // Reset state
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_s_rstrb", s_rstrb, 1'b0);
    check_val("rst_s_wmask", s_wmask, 4'h0);
    check_val("rst_busy", {m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy}, 4'h0);
    check_val("rst_s_addr", s_addr, 32'h0);
    check_val("rst_s_wdata", s_wdata, 32'h0);
    check_val("rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
    check_val("rst_grant", grant_id, 1'b0);
    check_val("rst_perr", proto_err, 1'b0);
    nxt();
    reset = 1'b1;

    // Single zero-wait read from m0
    nxt();
    wait_n = 0; rd_val = 32'hDEADBEEF;
    m0_addr = 32'h10; m0_rstrb = 1'b1;
    push_exp(1'b0, 32'h10, m0_wdata, 4'h0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      nxt();
      idle_inputs();
      @(negedge clk);
      check_val("rd1_rstrb", s_rstrb, k == 1);
      check_val("rd1_rbusy", m0_rbusy, k <= 2);
    end
    check_val("rd1_rdata", m0_rdata, 32'hDEADBEEF);

    // Simultaneous m0 read and m1 write straight after reset
    do_reset();
    rd_val = 32'h12345678;
    m0_addr = 32'h20; m0_rstrb = 1'b1;
    m1_addr = 32'h0040_0100; m1_wdata = 32'h41; m1_wmask = 4'b0001;
    push_exp(1'b0, 32'h20, m0_wdata, 4'h0, 1'b0);
    push_exp(1'b1, 32'h0040_0100, 32'h41, 4'b0001, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      nxt();
      idle_inputs();
      @(negedge clk);
      check_val("sim_m0_rstrb", s_rstrb, k == 1);
      check_val("sim_m1_wmask", s_wmask, (k == 4) ? 4'h1 : 4'h0);
      check_val("sim_m1_wbusy", m1_wbusy, k <= 5);
      if (k == 3) check_val("sim_m0_rdata", {m0_rbusy, m0_rdata}, {1'b0, 32'h12345678});
    end

    // Slave wait states on an m1 read
    nxt();
    wait_n = 3; rd_val = 32'hCAFEF00D;
    m1_addr = 32'h30; m1_rstrb = 1'b1;
    push_exp(1'b1, 32'h30, m1_wdata, 4'h0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      nxt();
      idle_inputs();
      @(negedge clk);
      check_val("ws_rbusy", m1_rbusy, k <= 5);
    end
    check_val("ws_rdata", m1_rdata, 32'hCAFEF00D);

    // Fairness: each master re-requests in its own completion cycle
    nxt();
    wait_n = 0; rd_val = 32'h600D0000;
    m0_addr = 32'h100; m1_addr = 32'h200; m0_rstrb = 1'b1; m1_rstrb = 1'b1;
    push_exp(1'b0, 32'h100, m0_wdata, 4'h0, 1'b0);
    push_exp(1'b1, 32'h200, m1_wdata, 4'h0, 1'b0);
    made = 2; issued = 0;
    for (int c = 0; c < 80 && issued < 8; c++) begin
      @(negedge clk);
      r0 = 1'b0; r1 = 1'b0;
      if (s_rstrb) begin
        glog.push_back(grant_id);
        issued++;
        if (made < 8) begin
          if (grant_id) r1 = 1'b1; else r0 = 1'b1;
          made++;
        end
      end
      nxt();
      m0_rstrb = r0; m1_rstrb = r1;
      if (r0) begin
        m0_addr = 32'h100 + made * 16;
        push_exp(1'b0, m0_addr, m0_wdata, 4'h0, 1'b0);
      end
      if (r1) begin
        m1_addr = 32'h200 + made * 16;
        push_exp(1'b1, m1_addr, m1_wdata, 4'h0, 1'b0);
      end
    end
    idle_inputs();
    repeat (4) nxt();
    @(negedge clk);
    check_val("fair_count", glog.size(), 8);
    for (int i = 0; i < glog.size(); i++) check_val("fair_order", glog[i], i % 2);
    check_val("fair_no_perr", proto_err, 1'b0);

    // Protocol error: m1 strobes again while its read is in flight
    nxt();
    base = n_strobe;
    rd_val = 32'h5A5A0050;
    m1_addr = 32'h50; m1_rstrb = 1'b1;
    push_exp(1'b1, 32'h50, m1_wdata, 4'h0, 1'b0);
    @(negedge clk);
    check_val("perr_before", proto_err, 1'b0);
    nxt();
    m1_addr = 32'h60; m1_rstrb = 1'b1;
    @(negedge clk);
    check_val("perr_rbusy", m1_rbusy, 1'b1);
    nxt();
    idle_inputs();
    @(negedge clk);
    check_val("perr_set", proto_err, 1'b1);
    repeat (5) nxt();
    check_val("perr_one_strobe", n_strobe - base, 1);
    @(negedge clk);
    check_val("perr_sticky", proto_err, 1'b1);
    check_val("perr_rdata", {m1_rbusy, m1_rdata}, {1'b0, 32'h5A5A0050});

    // Write wins over a simultaneous rstrb
    nxt();
    m0_addr = 32'h70; m0_wdata = 32'h99; m0_wmask = 4'b0010; m0_rstrb = 1'b1;
    push_exp(1'b0, 32'h70, 32'h99, 4'b0010, 1'b1);
    nxt();
    idle_inputs();
    @(negedge clk);
    check_val("ww_busy", {m0_rbusy, m0_wbusy}, 2'b01);
    repeat (3) nxt();

    // Reset asserted while m1 sits in WWAIT
    wait_n = 5;
    m1_addr = 32'h0040_0000; m1_wdata = 32'h55; m1_wmask = 4'hF;
    push_exp(1'b1, 32'h0040_0000, 32'h55, 4'hF, 1'b1);
    nxt();
    idle_inputs();
    @(negedge clk);
    check_val("abort_grant", grant_id, 1'b1);
    nxt();
    @(negedge clk);
    check_val("abort_wbusy_pre", m1_wbusy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_val("abort_s_strobes", {s_rstrb, s_wmask}, 5'h0);
    check_val("abort_busy", {m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy}, 4'h0);
    check_val("abort_grant0", grant_id, 1'b0);
    check_val("abort_perr", proto_err, 1'b0);
    check_val("abort_rdata", {m0_rdata, m1_rdata}, 64'h0);
    nxt();
    reset = 1'b1;
    base = n_strobe;
    repeat (10) nxt();
    check_val("abort_quiet", n_strobe - base, 0);

    // Normal service after the abort
    wait_n = 0; rd_val = 32'h80808080;
    m0_addr = 32'h80; m0_rstrb = 1'b1;
    push_exp(1'b0, 32'h80, m0_wdata, 4'h0, 1'b0);
    repeat (3) begin
      nxt();
      idle_inputs();
    end
    @(negedge clk);
    check_val("post_rdata", {m0_rbusy, m0_rdata}, {1'b0, 32'h80808080});
    check_val("sb_leftover", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/soc_bus_arbiter.md
Name: soc_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the SoC memory bus, which carries block RAM plus the IO window at address bit 22.
- Master 0 is the FemtoRV32 core. Master 1 is a secondary bus master, such as a UART firmware loader or debug monitor.
- Each request is captured, arbitrated round-robin, and issued to the shared slave as a single strobe. The requesting master is held on its own rbusy/wbusy until the transfer completes.
- It sits between the processor bus signals and the RAM/IO decode and read-mux logic.

Parameters:
- ADDR_WIDTH, 32, width of master and slave addresses.
- DATA_WIDTH, 32, data width; the write mask is DATA_WIDTH/8 bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- mN_addr  in  ADDR_WIDTH  master N address (N = 0, 1; applies to every mN_* port below).
- mN_wdata  in  DATA_WIDTH  master N write data.
- mN_wmask  in  4  master N byte write mask; nonzero for one cycle starts a write.
- mN_rstrb  in  1  master N read strobe, a one-cycle pulse.
- mN_rdata  out  DATA_WIDTH  master N read data, registered.
- mN_rbusy  out  1  master N read in progress.
- mN_wbusy  out  1  master N write in progress.
- s_addr  out  ADDR_WIDTH  slave address.
- s_wdata  out  DATA_WIDTH  slave write data.
- s_wmask  out  4  slave write mask, a one-cycle pulse.
- s_rstrb  out  1  slave read strobe, a one-cycle pulse.
- s_rdata  in  DATA_WIDTH  slave read data.
- s_rbusy  in  1  slave read busy.
- s_wbusy  in  1  slave write busy.
- grant_id  out  1  master owning the slave (0 or 1); valid while state is not IDLE.
- proto_err  out  1  sticky; set on a request from a master that is already busy.

Behaviour:
- Reset values:
  - all mN_rbusy, mN_wbusy, s_rstrb, s_wmask = 0
  - s_addr, s_wdata, mN_rdata = 0
  - grant_id = 0, proto_err = 0
  - round-robin pointer favours m0; both pending slots empty; state IDLE.
- Capture:
  - Request = mN_rstrb or (mN_wmask != 0) in cycle T.
  - Addr, wdata, wmask and type are latched into pending slot N at the T edge.
  - mN_rbusy (read) or mN_wbusy (write) is high from T+1 until completion.
  - If rstrb and wmask are both set in the same cycle, the write wins and rstrb is ignored.
- Protocol errors: a request from a master whose slot is pending or in service is dropped, proto_err is set, and the current transfer is unaffected.
- States and transitions:
  - IDLE -> ISSUE when any slot is pending.
  - ISSUE:
    - grant_id is chosen by round-robin: the non-last-granted master first if both are pending.
    - That master's slot drives s_addr/s_wdata.
    - Exactly one cycle of s_rstrb=1 (read) or s_wmask=slot mask (write) is emitted.
    - Next state is RWAIT or WWAIT.
  - RWAIT:
    - On the first cycle with s_rbusy=0, s_rdata is captured into mG_rdata and mG_rbusy clears on the next edge.
    - The slot is freed, the pointer updates, and the state returns to IDLE.
  - WWAIT: on the first cycle with s_wbusy=0, mG_wbusy clears, the slot is freed, the pointer updates, and the state returns to IDLE.
- Latency:
  - With no contention and a zero-wait slave, a read strobed at T has s_rstrb at T+1 and data sampled at T+2.
  - mN_rbusy is high for T+1..T+2, low at T+3, with mN_rdata valid.
  - A write at T has s_wmask at T+1; wbusy is high T+1..T+2.
- Data hold: s_addr and s_wdata stay stable from ISSUE until the return to IDLE. mN_rdata holds until the next read completes for that master.
- Back-to-back throughput: a new request may be captured in the same cycle a transfer completes.
- Simultaneous requests: both are captured and serviced in pointer order, with no loss. The second master's busy stays high throughout its wait.
- Starvation: continuous requests from both masters alternate strictly.
- Reset mid-transfer: reset asserted in any state aborts immediately and returns all outputs and slots to their reset values. No strobe is emitted after reset deasserts until a new request arrives.

Test Plan:
- Single read: m0_rstrb at T with addr 0x00000010 and a zero-wait slave returning 0xDEADBEEF -> s_rstrb only at T+1 with s_addr=0x10; m0_rbusy high T+1..T+2; m0_rdata=0xDEADBEEF and m0_rbusy=0 at T+3.
- Simultaneous requests: m0 read of 0x20 and m1 write of 0x00400100 (wmask 0001, wdata 0x41) at T after reset -> m0 issued first at T+1, m1 s_wmask=0001 at T+4; m1_wbusy high T+1..T+5.
- Wait states: slave holds s_rbusy high for 3 cycles after s_rstrb -> mN_rbusy extends by exactly 3 cycles; the data captured is the value present when s_rbusy falls.
- Fairness: both masters re-request immediately on every completion for 8 transfers -> grant order 0,1,0,1,0,1,0,1.
- Protocol error: m1_rstrb pulsed again while m1_rbusy=1 -> proto_err=1 and stays set; only one s_rstrb is issued for m1.
- Reset abort: reset asserted low in WWAIT -> s_wmask=0, all busy=0, grant_id=0 asynchronously. After release, no s_rstrb or s_wmask occurs until a new request.
